// File: rtl/qdiv_hs.sv
// rtl/qdiv_hs.sv - sequential sign-magnitude Q-format restoring divider with valid/ready handshake
// Optional round-to-nearest guard bit enabled by defining QDIV_ROUND_EN.
module qdiv_hs #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_overflow,
  output logic         o_dbz
);

  localparam int ITER = N + Q - 1;
`ifdef QDIV_ROUND_EN
  localparam int GB = 1;
`else
  localparam int GB = 0;
`endif
  localparam int QW = ITER + GB;
  localparam int DW = QW + N - 2;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_nx;
  logic [QW-1:0] rem_q, quo_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;

  logic          accept, divisor_zero, ge;
  logic [QW-1:0] rem_sub, quo_step;
  logic [ITER-1:0] w;
  logic          ovf_t, ovf_f, res_sign;
  logic [N-2:0]  mag_f;

  assign divisor_zero = (i_divisor[N-2:0] == '0);
  assign accept       = (state == S_IDLE) && i_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = divisor_zero ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Once ge holds the divisor's upper bits are zero, so a QW-bit subtract suffices.
  always_comb begin
    ge       = ({{(DW-QW){1'b0}}, rem_q} >= div_q);
    rem_sub  = rem_q - div_q[QW-1:0];
    quo_step = quo_q;
    if (ge) quo_step[cnt_q] = 1'b1;
  end

  assign w     = quo_step[QW-1:GB];
  assign ovf_t = |w[ITER-1:N-1];

`ifdef QDIV_ROUND_EN
  logic [N-1:0] mag_r;
  always_comb begin
    mag_r = {1'b0, w[N-2:0]} + {{(N-1){1'b0}}, quo_step[0]};
    ovf_f = ovf_t | mag_r[N-1];
    mag_f = ovf_f ? '1 : mag_r[N-2:0];
  end
`else
  always_comb begin
    ovf_f = ovf_t;
    mag_f = ovf_f ? '1 : w[N-2:0];
  end
`endif

  assign res_sign = sign_q & (|mag_f);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      o_quotient <= '0;
      o_overflow <= 1'b0;
      o_dbz      <= 1'b0;
    end else begin
      if (accept) begin
        sign_q     <= i_dividend[N-1] ^ i_divisor[N-1];
        rem_q      <= {i_dividend[N-2:0], {(Q+GB){1'b0}}};
        div_q      <= {i_divisor[N-2:0], {(QW-1){1'b0}}};
        quo_q      <= '0;
        cnt_q      <= CW'(QW - 1);
        o_overflow <= 1'b0;
        o_dbz      <= 1'b0;
        if (divisor_zero) begin
          o_quotient <= {i_dividend[N-1] ^ i_divisor[N-1], {(N-1){1'b1}}};
          o_dbz      <= 1'b1;
        end
      end else if (state == S_BUSY) begin
        if (ge) rem_q <= rem_sub;
        div_q <= div_q >> 1;
        quo_q <= quo_step;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          o_quotient <= {res_sign, mag_f};
          o_overflow <= ovf_f;
        end
      end
    end
  end

endmodule

// File: tb/tb_qdiv_hs.sv
// tb/tb_qdiv_hs.sv - self-checking bench for qdiv_hs against an arithmetic reference model
module tb_qdiv_hs;

  localparam int N    = 32;
  localparam int Q    = 15;
  localparam int ITER = N + Q - 1;
`ifdef QDIV_ROUND_EN
  localparam int LAT = ITER + 2;
  localparam logic [31:0] THIRD = 32'h00002AAB;
`else
  localparam int LAT = ITER + 1;
  localparam logic [31:0] THIRD = 32'h00002AAA;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dd = '0, dv = '0;
  logic        iv = 1'b0, ir = 1'b0;
  logic        o_ready, o_valid, o_overflow, o_dbz;
  logic [31:0] o_quotient;

  int checks = 0;
  int errors = 0;

  qdiv_hs #(.N(N), .Q(Q)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_dividend (dd),
    .i_divisor  (dv),
    .i_valid    (iv),
    .o_ready    (o_ready),
    .o_quotient (o_quotient),
    .o_valid    (o_valid),
    .i_ready    (ir),
    .o_overflow (o_overflow),
    .o_dbz      (o_dbz)
  );

  always #5 clk = ~clk;

  // Real-valued division on magnitudes, then saturation and sign rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ov, output logic dz);
    longint unsigned ma, mb, m;
    logic s;
    ma = 64'(a[30:0]);
    mb = 64'(b[30:0]);
    s  = a[31] ^ b[31];
    ov = 1'b0;
    dz = 1'b0;
    if (mb == 0) begin
      dz = 1'b1;
      q  = {s, 31'h7FFFFFFF};
    end else begin
`ifdef QDIV_ROUND_EN
      m = (ma << (Q + 1)) / mb;
      m = (m >> 1) + (m & 64'd1);
`else
      m = (ma << Q) / mb;
`endif
      if (m > 64'h7FFFFFFF) begin
        ov = 1'b1;
        m  = 64'h7FFFFFFF;
      end
      q = {s && (m != 0), m[30:0]};
    end
  endfunction

  task automatic start_wait(input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit to);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    dd = a; dv = b; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 1;
    while (!o_valid && lat < LAT + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !o_valid;
  endtask

  task automatic handoff();
    ir = 1'b1;
    @(posedge clk); #1;
    ir = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 1'b1; dd = 32'h00018000; dv = 32'h00010000;
    repeat (3) @(posedge clk);
    #1;
    iv = 1'b0; rst = 1'b0;
    checks++;
    if ({o_ready, o_valid, o_overflow, o_dbz} !== 4'b1000 || o_quotient !== 32'h0) begin
      errors++;
      $display("FAIL reset rdy/vld/ovf/dbz/q got %b%b%b%b %h want 1000 00000000",
               o_ready, o_valid, o_overflow, o_dbz, o_quotient);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h00018000, 32'h80008000, 32'h00008000, 32'h80008000, 32'h80000000, 32'h00008000};
    logic [31:0] tb [6] = '{32'h00010000, 32'h00020000, 32'h80020000, 32'h80020000, 32'h00008000, 32'h00018000};
    logic [31:0] te [6] = '{32'h0000C000, 32'h80002000, 32'h80002000, 32'h00002000, 32'h00000000, THIRD};
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      start_wait(ta[i], tb[i], lat, to);
      checks++;
      if (to || o_quotient !== te[i] || o_overflow !== 1'b0 || o_dbz !== 1'b0 || lat != LAT) begin
        errors++;
        $display("FAIL directed[%0d] q=%h ovf=%b dbz=%b lat=%0d to=%0d want q=%h ovf=0 dbz=0 lat=%0d",
                 i, o_quotient, o_overflow, o_dbz, lat, to, te[i], LAT);
      end
      handoff();
    end
  endtask

  task automatic test_dbz();
    int lat;
    bit to;
    start_wait(32'h00028000, 32'h80000000, lat, to);
    checks++;
    if (to || lat != 1 || o_quotient !== 32'hFFFFFFFF || o_dbz !== 1'b1 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL dbz q=%h dbz=%b ovf=%b lat=%0d want q=ffffffff dbz=1 ovf=0 lat=1",
               o_quotient, o_dbz, o_overflow, lat);
    end
    handoff();
  endtask

  task automatic test_overflow();
    logic [31:0] ta [2] = '{32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [2] = '{32'h7FFFFFFF, 32'hFFFFFFFF};
    int lat;
    bit to;
    for (int i = 0; i < 2; i++) begin
      start_wait(ta[i], 32'h00000001, lat, to);
      checks++;
      if (to || o_quotient !== te[i] || o_overflow !== 1'b1 || o_dbz !== 1'b0) begin
        errors++;
        $display("FAIL overflow[%0d] q=%h ovf=%b dbz=%b want q=%h ovf=1 dbz=0",
                 i, o_quotient, o_overflow, o_dbz, te[i]);
      end
      handoff();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq;
    logic eo, ez;
    int lat, sh;
    bit to;
    for (int i = 0; i < 40; i++) begin
      sh = $urandom_range(0, 31);
      a  = $urandom;
      b  = ($urandom & 32'h7FFFFFFF) >> sh;
      if ($urandom_range(0, 1) == 1) b[31] = 1'b1;
      if (i % 13 == 0) a[30:0] = '0;
      model(a, b, eq, eo, ez);
      start_wait(a, b, lat, to);
      checks++;
      if (to || o_quotient !== eq || o_overflow !== eo || o_dbz !== ez ||
          lat != (ez ? 1 : LAT)) begin
        errors++;
        $display("FAIL random %h/%h q=%h ovf=%b dbz=%b lat=%0d want q=%h ovf=%b dbz=%b",
                 a, b, o_quotient, o_overflow, o_dbz, lat, eq, eo, ez);
      end
      handoff();
    end
  endtask

  task automatic test_backpressure_reset();
    int lat;
    bit to;
    logic [31:0] eq;
    logic eo, ez;
    start_wait(32'h00018000, 32'h00010000, lat, to);
    for (int i = 0; i < 10; i++) begin
      dd = $urandom; dv = 32'h00000001; iv = i[0];
      @(posedge clk); #1;
      iv = 1'b0;
      checks++;
      if (to || o_valid !== 1'b1 || o_ready !== 1'b0 || o_quotient !== 32'h0000C000 ||
          o_overflow !== 1'b0 || o_dbz !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] vld=%b rdy=%b q=%h ovf=%b dbz=%b want vld=1 rdy=0 q=0000c000 ovf=0 dbz=0",
                 i, o_valid, o_ready, o_quotient, o_overflow, o_dbz);
      end
    end
    handoff();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handoff vld=%b rdy=%b want vld=0 rdy=1", o_valid, o_ready);
    end
    dd = 32'h7FFFFFFF; dv = 32'h00000003; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_quotient !== 32'h0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset vld=%b rdy=%b q=%h ovf=%b want vld=0 rdy=1 q=00000000 ovf=0",
               o_valid, o_ready, o_quotient, o_overflow);
    end
    model(32'h00018000, 32'h00010000, eq, eo, ez);
    start_wait(32'h00018000, 32'h00010000, lat, to);
    checks++;
    if (to || o_quotient !== eq || lat != LAT) begin
      errors++;
      $display("FAIL post_reset q=%h lat=%0d want q=%h lat=%0d", o_quotient, lat, eq, LAT);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    int n;
    dd = 32'h00018000; dv = 32'h00010000; iv = 1'b1; ir = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (!o_valid && n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_quotient !== 32'h0000C000) begin
      errors++;
      $display("FAIL b2b_first vld=%b rdy=%b q=%h want vld=1 rdy=0 q=0000c000",
               o_valid, o_ready, o_quotient);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble vld=%b rdy=%b want vld=0 rdy=1", o_valid, o_ready);
    end
    @(posedge clk); #1;
    iv = 1'b0;
    n = 1;
    while (!o_valid && n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_valid !== 1'b1 || n != LAT || o_quotient !== 32'h0000C000) begin
      errors++;
      $display("FAIL b2b_second vld=%b lat=%0d q=%h want vld=1 lat=%0d q=0000c000",
               o_valid, n, o_quotient, LAT);
    end
    @(posedge clk); #1;
    ir = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dbz();
    test_overflow();
    test_random();
    test_backpressure_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
